// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and types for the scoreboarded register file
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with issue/write-back/flush priority
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEFAULT,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic             flush,
  output logic             iss_ready,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             iss_take;

  // A destination may be claimed when it has no outstanding writer, or when
  // that writer retires in this very cycle.
  assign iss_ready = en && ((iss_rd == '0) || !busy_q[iss_rd] ||
                            (wb_valid && (wb_rd == iss_rd)));
  assign iss_take  = iss_valid && iss_ready && !flush;

  // Write-back clears first so a same-cycle issue to the same register wins;
  // flush overrides everything; x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (flush) busy_d = '0;
    else if (iss_take) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy state register; en = 0 holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else if (en) busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with busy scoreboard and write-back bypass
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEFAULT,
  parameter  int NREGS  = NREGS_DEFAULT,
  parameter  int NREAD  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_ready,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic                  iss_ready,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy
);

  logic [XLEN-1:0] regs [NREGS];

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .iss_ready (iss_ready),
    .busy      (busy)
  );

  // Storage; x0 is never written so it keeps its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (en && wb_valid && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = rd_addr[p*AW +: AW];
    // Forward the retiring value so a consumer need not wait a cycle for it.
    assign hit  = (BYPASS != 0) && wb_valid && (wb_rd == addr) && (addr != '0);

    assign rd_data[p*XLEN +: XLEN] = !en ? '0 : (hit ? wb_data : regs[addr]);
    assign rd_ready[p]             = en && (hit || !busy[addr]);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard-driven self-checking bench for regfile_sb
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [AW-1:0]    a0, a1;
  logic [2*AW-1:0]  rd_addr;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             flush;

  logic [2*XLEN-1:0] rd_data, rd_data_nb;
  logic [1:0]        rd_ready, rd_ready_nb;
  logic              iss_ready, iss_ready_nb;
  logic [NREGS-1:0]  busy, busy_nb;

  assign rd_addr = {a1, a0};

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ready(rd_ready), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .busy(busy)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .en(en), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_ready(rd_ready_nb), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_ready(iss_ready_nb), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .busy(busy_nb)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input string tag);
    if (tag == "rd0")            return rd_data[31:0];
    else if (tag == "rd1")       return rd_data[63:32];
    else if (tag == "rd_ready")  return 32'(rd_ready);
    else if (tag == "iss_ready") return 32'(iss_ready);
    else if (tag == "busy")      return busy;
    else if (tag == "nb_rd0")    return rd_data_nb[31:0];
    else if (tag == "nb_rd1")    return rd_data_nb[63:32];
    else                         return 32'hxxxx_xxxx;
  endfunction

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, observe(e.tag), e.val);
    end
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic smp();
    @(negedge clk);
    drain();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; a0 = '0; a1 = 5'd5;
    iss_valid = 1'b0; iss_rd = '0; wb_valid = 1'b0; wb_rd = '0;
    wb_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    a0 = 5'd0;
    expect_val("rd0", 32'h0); expect_val("rd1", 32'h0);
    expect_val("rd_ready", 32'h3); expect_val("busy", 32'h0);
    expect_val("iss_ready", 32'h1);
    smp();

    // write-back x5 with same-cycle read
    cyc(); wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    expect_val("rd1", 32'hDEADBEEF); expect_val("nb_rd1", 32'h0);
    expect_val("rd_ready", 32'h3);
    smp();
    cyc();
    expect_val("rd1", 32'hDEADBEEF); expect_val("nb_rd1", 32'hDEADBEEF);
    smp();

    // issue x7, then it reads busy
    cyc(); iss_valid = 1'b1; iss_rd = 5'd7; a0 = 5'd7;
    expect_val("rd_ready", 32'h3); expect_val("iss_ready", 32'h1);
    smp();
    cyc(); iss_rd = 5'd7;
    expect_val("rd_ready", 32'h2); expect_val("iss_ready", 32'h0);
    expect_val("busy", 32'h0000_0080);
    smp();
    cyc(); wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
    expect_val("rd0", 32'h1234); expect_val("rd_ready", 32'h3);
    expect_val("iss_ready", 32'h1);
    smp();
    cyc();
    expect_val("busy", 32'h0); expect_val("rd0", 32'h1234);
    smp();

    // same-cycle issue and write-back of x9
    cyc(); iss_valid = 1'b1; iss_rd = 5'd9; wb_valid = 1'b1; wb_rd = 5'd9;
    wb_data = 32'h55; a0 = 5'd9;
    expect_val("iss_ready", 32'h1); expect_val("rd0", 32'h55);
    smp();
    cyc();
    expect_val("busy", 32'h0000_0200); expect_val("rd0", 32'h55);
    expect_val("rd_ready", 32'h2);
    smp();

    // x0 ignores writes
    cyc(); wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; a0 = 5'd0;
    expect_val("rd0", 32'h0); expect_val("rd_ready", 32'h3);
    smp();
    cyc();
    expect_val("rd0", 32'h0); expect_val("busy", 32'h0000_0200);
    smp();

    // issue x3, x4, then flush with issue x6
    cyc(); iss_valid = 1'b1; iss_rd = 5'd3;
    cyc(); iss_valid = 1'b1; iss_rd = 5'd4;
    cyc(); flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6;
    expect_val("busy", 32'h0000_0218); expect_val("iss_ready", 32'h1);
    smp();
    cyc();
    expect_val("busy", 32'h0);
    smp();

    // busy x8, then asynchronous reset mid-cycle
    cyc(); iss_valid = 1'b1; iss_rd = 5'd8; a0 = 5'd5;
    cyc();
    #2;
    expect_val("busy", 32'h0000_0100); expect_val("rd0", 32'hDEADBEEF);
    drain();
    rst = 1'b1;
    #1;
    expect_val("busy", 32'h0); expect_val("rd0", 32'h0);
    drain();
    #1 rst = 1'b0;

    // en = 0 freezes state and gates outputs
    cyc(); wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5;
    cyc(); en = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h77;
    iss_valid = 1'b1; iss_rd = 5'd5;
    expect_val("rd0", 32'h0); expect_val("rd_ready", 32'h0);
    expect_val("iss_ready", 32'h0);
    smp();
    cyc(); en = 1'b1;
    expect_val("rd0", 32'hA5); expect_val("busy", 32'h0);
    expect_val("rd_ready", 32'h3);
    smp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
